// File: rtl/avalon_ram_pkg.sv
// avalon_ram_pkg: shared FSM type, bus width and default geometry for the wait-state RAM
package avalon_ram_pkg;
    localparam int BUS_W           = 32;
    localparam int DEF_ADDR_BITS   = 8;
    localparam int DEF_WAIT_STATES = 2;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/ram_word_array.sv
// ram_word_array: word-wide storage with four byte-lane write enables and an asynchronous read port
module ram_word_array
    import avalon_ram_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic [3:0]       we_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic [BUS_W-1:0] wdata_i,
    input  logic [IDX_W-1:0] ridx_i,
    output logic [BUS_W-1:0] rdata_o
);
    logic [BUS_W-1:0] mem_q [2**IDX_W];
    always_ff @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (we_i[i]) mem_q[widx_i][8*i +: 8] <= wdata_i[8*i +: 8];
    assign rdata_o = mem_q[ridx_i];
endmodule

// File: rtl/avalon_waitstate_ram.sv
// avalon_waitstate_ram: Avalon-MM slave RAM with a fixed number of wait states and a preload port
module avalon_waitstate_ram
    import avalon_ram_pkg::*;
#(
    parameter int ADDR_BITS   = DEF_ADDR_BITS,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BUS_W-1:0] address,
    input  logic             read,
    input  logic             write,
    input  logic [BUS_W-1:0] writedata,
    input  logic [3:0]       byteenable,
    output logic             waitrequest,
    output logic [BUS_W-1:0] readdata,
    input  logic             load_valid,
    input  logic [7:0]       load_addr,
    input  logic [BUS_W-1:0] load_data,
    output logic             load_ready
);
    localparam int IDX_W = ADDR_BITS - 2;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d, be_q, be_d, ram_we;
    logic [IDX_W-1:0] idx_q, idx_d, ridx, widx;
    logic [BUS_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, ram_rdata, ram_wdata;
    logic wr_q, wr_d, req, bus_we, load_fire, unused_bits;
    assign req         = read | write;
    assign waitrequest = req && state_q != S_DONE;
    assign load_ready  = state_q == S_IDLE && !req;
    assign load_fire   = load_valid && load_ready;
    // A bus write lands only if the master still holds its request in DONE.
    assign bus_we      = state_q == S_DONE && wr_q && req;
    assign ram_we      = bus_we ? be_q : {4{load_fire}};
    assign widx        = bus_we ? idx_q : load_addr[ADDR_BITS-1:2];
    assign ram_wdata   = bus_we ? wdata_q : load_data;
    assign ridx        = state_q == S_IDLE ? address[ADDR_BITS-1:2] : idx_q;
    assign readdata    = rdata_q;
    assign unused_bits = ^{address, load_addr};
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: if (req) begin
                idx_d   = address[ADDR_BITS-1:2];
                wdata_d = writedata;
                be_d    = byteenable;
                wr_d    = write;
                cnt_d   = CNT_INIT;
                state_d = WAIT_STATES > 0 ? S_WAIT : S_DONE;
                if (WAIT_STATES == 0 && !write) rdata_d = ram_rdata;
            end
            S_WAIT: if (!req) state_d = S_IDLE;
                else if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    if (!wr_q) rdata_d = ram_rdata;
                end else cnt_d = cnt_q - 4'd1;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= 4'd0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    ram_word_array #(.IDX_W(IDX_W)) u_ram (
        .clk    (clk),
        .we_i   (ram_we),
        .widx_i (widx),
        .wdata_i(ram_wdata),
        .ridx_i (ridx),
        .rdata_o(ram_rdata)
    );
endmodule

// File: tb/tb_avalon_waitstate_ram.sv
// tb_avalon_waitstate_ram: random and directed scoreboard bench over a 2-wait-state and a 0-wait-state RAM
module tb_avalon_waitstate_ram;
    typedef struct {
        int          d;
        logic [31:0] rd;
        int          st;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd [2], wr [2], lv [2], wreq [2], lrdy [2];
    logic [31:0] addr [2], wdat [2], ldat [2], rdat [2];
    logic [3:0]  be [2];
    logic [7:0]  lad [2];
    logic [31:0] mem_m [2][64];
    logic [31:0] rd_m [2];
    int          ws [2] = '{2, 0};
    int          st [2] = '{0, 0};
    exp_t        exp_q [$];
    exp_t        mon_e;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        avalon_waitstate_ram #(.ADDR_BITS(8), .WAIT_STATES(g == 0 ? 2 : 0)) dut (
            .clk        (clk),
            .reset      (rst_n),
            .address    (addr[g]),
            .read       (rd[g]),
            .write      (wr[g]),
            .writedata  (wdat[g]),
            .byteenable (be[g]),
            .waitrequest(wreq[g]),
            .readdata   (rdat[g]),
            .load_valid (lv[g]),
            .load_addr  (lad[g]),
            .load_data  (ldat[g]),
            .load_ready (lrdy[g])
        );
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Bus access with normal handshake; expectations are queued before the request is raised.
    task automatic bus(int d, logic r, logic w, logic [31:0] a, logic [31:0] wd, logic [3:0] b);
        exp_t e;
        int   idx, n;
        idx  = int'(a[7:2]);
        e.d  = d;
        e.st = ws[d] + 1;
        if (w) begin
            for (int i = 0; i < 4; i++)
                if (b[i]) mem_m[d][idx][8*i +: 8] = wd[8*i +: 8];
        end else rd_m[d] = mem_m[d][idx];
        e.rd = rd_m[d];
        exp_q.push_back(e);
        rd[d] = r; wr[d] = w; addr[d] = a; wdat[d] = wd; be[d] = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (wreq[d] && n < 40);
        check($sformatf("dut%0d handshake", d), 32'(wreq[d]), 32'd0);
        @(posedge clk); #1;
        rd[d] = 1'b0; wr[d] = 1'b0;
    endtask

    task automatic load(int d, logic [7:0] la, logic [31:0] ld);
        lv[d] = 1'b1; lad[d] = la; ldat[d] = ld;
        @(negedge clk);
        check($sformatf("dut%0d load_ready idle", d), 32'(lrdy[d]), 32'd1);
        mem_m[d][int'(la[7:2])] = ld;
        @(posedge clk); #1;
        lv[d] = 1'b0;
    endtask

    // Master drops its request after k stalled cycles; nothing may change.
    task automatic abort(int d, logic r, logic [31:0] a, int k);
        rd[d] = r; wr[d] = !r; addr[d] = a; wdat[d] = $urandom; be[d] = 4'hF;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            check($sformatf("dut%0d abort stall", d), 32'(wreq[d]), 32'd1);
        end
        @(posedge clk); #1;
        rd[d] = 1'b0; wr[d] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n || !(rd[d] || wr[d])) st[d] = 0;
            else if (wreq[d]) st[d]++;
            else begin
                check($sformatf("dut%0d pending", d), 32'(exp_q.size()), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check($sformatf("dut%0d readdata", d), rdat[d], mon_e.rd);
                    check($sformatf("dut%0d stall cycles", d), 32'(st[d]), 32'(mon_e.st));
                end
                st[d] = 0;
            end
            if (rst_n && (rd[d] || wr[d]))
                check($sformatf("dut%0d load_ready busy", d), 32'(lrdy[d]), 32'd0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          d, op, k;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 0; wr[i] = 0; lv[i] = 0; addr[i] = 0; wdat[i] = 0;
            ldat[i] = 0; be[i] = 0; lad[i] = 0; rd_m[i] = 0;
        end
        repeat (3) @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("dut%0d reset readdata", i), rdat[i], 32'd0);
            check($sformatf("dut%0d reset load_ready", i), 32'(lrdy[i]), 32'd1);
            check($sformatf("dut%0d reset waitrequest", i), 32'(wreq[i]), 32'd0);
        end
        rd[0] = 1'b1; #1;
        check("reset waitrequest with request", 32'(wreq[0]), 32'd1);
        check("reset load_ready with request", 32'(lrdy[0]), 32'd0);
        rd[0] = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 64; j++) load(i, 8'(j * 4), $urandom);
        load(0, 8'h04, 32'h24020010);
        bus(0, 1, 0, 32'hBFC00004, 0, 0);
        load(0, 8'h08, 32'h11223344);
        bus(0, 0, 1, 32'h08, 32'hAABBCCDD, 4'b0101);
        bus(0, 1, 0, 32'h08, 0, 0);
        bus(0, 0, 1, 32'h08, 32'h55555555, 4'b0000);
        bus(0, 1, 0, 32'h08, 0, 0);
        bus(1, 1, 0, 32'h0C, 0, 0);
        bus(1, 1, 0, 32'h10, 0, 0);
        bus(1, 1, 0, 32'h0C, 0, 0);
        lv[0] = 1'b1; lad[0] = 8'h20; ldat[0] = 32'hCAFEF00D;
        bus(0, 1, 0, 32'h20, 0, 0);
        @(negedge clk);
        check("load_ready after read", 32'(lrdy[0]), 32'd1);
        mem_m[0][8] = 32'hCAFEF00D;
        @(posedge clk); #1;
        lv[0] = 1'b0;
        bus(0, 1, 0, 32'h20, 0, 0);
        bus(0, 1, 0, 32'h14, 0, 0);
        abort(0, 0, 32'h14, 1);
        abort(0, 0, 32'h14, 3);
        bus(0, 1, 0, 32'h14, 0, 0);
        wr[0] = 1'b1; addr[0] = 32'h14; wdat[0] = 32'hDEADBEEF; be[0] = 4'hF;
        @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        check("mid-wait reset readdata", rdat[0], 32'd0);
        check("mid-wait reset waitrequest", 32'(wreq[0]), 32'd1);
        check("mid-wait reset load_ready", 32'(lrdy[0]), 32'd0);
        wr[0] = 1'b0; #1;
        check("reset idle load_ready", 32'(lrdy[0]), 32'd1);
        rd_m[0] = 0; rd_m[1] = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        bus(0, 0, 1, 32'h14, 32'h01020304, 4'b1000);
        bus(0, 1, 0, 32'h14, 0, 0);
        bus(0, 1, 1, 32'h18, 32'h70, 4'hF);
        bus(0, 1, 0, 32'h18, 0, 0);
        for (int it = 0; it < 200; it++) begin
            d  = $urandom_range(0, 1);
            op = $urandom_range(0, 5);
            a  = $urandom;
            case (op)
                0, 1: bus(d, 1, 0, a, 0, 4'($urandom));
                2: bus(d, 0, 1, a, $urandom, 4'($urandom));
                3: bus(d, 1, 1, a, $urandom, 4'($urandom));
                4: if (d == 0) begin
                    k = $urandom_range(1, 2);
                    if ($urandom_range(0, 1) == 1) abort(0, 1, a, k);
                    else abort(0, 0, a, k + $urandom_range(0, 1));
                end else bus(1, 1, 0, a, 0, 0);
                default: begin
                    k = $urandom_range(1, 3);
                    for (int j = 0; j < k; j++) load(d, 8'($urandom), $urandom);
                end
            endcase
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 64; j++) bus(i, 1, 0, 32'(j * 4), 0, 0);
        repeat (3) @(posedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
